// File: rtl/serial_word_comparator_pkg.sv
// Shared types and constants for serial_word_comparator: FSM states, digit width
// and the one-hot lt/eq/gt result encoding.
package serial_word_comparator_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned DigitW = 2;

    // Bit positions inside the result vector {gt, eq, lt}
    localparam int unsigned ResLtIdx = 0;
    localparam int unsigned ResEqIdx = 1;
    localparam int unsigned ResGtIdx = 2;

    localparam logic [2:0] ResNone = 3'b000;
    localparam logic [2:0] ResLt   = 3'b001;
    localparam logic [2:0] ResEq   = 3'b010;
    localparam logic [2:0] ResGt   = 3'b100;

    function automatic logic [2:0] res_unequal(input logic gt);
        return gt ? ResGt : ResLt;
    endfunction

endpackage

// File: rtl/cmp2_slice.sv
// Purely combinational magnitude compare of two unsigned 2-bit digits.
module cmp2_slice
    import serial_word_comparator_pkg::*;
(
    input  logic [DigitW-1:0] a_i,
    input  logic [DigitW-1:0] b_i,
    output logic              lt_o,
    output logic              eq_o,
    output logic              gt_o
);

    assign lt_o = (a_i < b_i);
    assign eq_o = (a_i == b_i);
    assign gt_o = (a_i > b_i);

endmodule

// File: rtl/serial_word_comparator.sv
// Multi-cycle unsigned comparator walking 2-bit digits MSB-first with a start/done handshake.
// Define SERIAL_CMP_EARLY_EXIT_EN to stop at the first unequal digit (data-dependent latency).
module serial_word_comparator
    import serial_word_comparator_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_lt_b,
    output logic             a_eq_b,
    output logic             a_gt_b
);

    localparam int unsigned NumDigits = WIDTH / DigitW;
    localparam int unsigned CntW      = (NumDigits > 1) ? $clog2(NumDigits) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(NumDigits - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [2:0]       res_q, res_d;
    logic             slice_lt, slice_eq, slice_gt;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
    logic             sticky_vld_q, sticky_vld_d;
    logic             sticky_gt_q, sticky_gt_d;
    logic             first_vld, first_gt;
`endif

    cmp2_slice u_cmp2_slice (
        .a_i  (a_sh_q[WIDTH-1 -: DigitW]),
        .b_i  (b_sh_q[WIDTH-1 -: DigitW]),
        .lt_o (slice_lt),
        .eq_o (slice_eq),
        .gt_o (slice_gt)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
        sticky_vld_d = sticky_vld_q;
        sticky_gt_d  = sticky_gt_q;
        // Earliest unequal digit wins, including the one on the shifter right now
        first_vld    = sticky_vld_q | ~slice_eq;
        first_gt     = sticky_vld_q ? sticky_gt_q : slice_gt;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    cnt_d   = CntLoad;
                    state_d = StRun;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
                    sticky_vld_d = 1'b0;
                    sticky_gt_d  = 1'b0;
`endif
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
                if (!slice_eq) begin
                    res_d   = res_unequal(slice_gt);
                    state_d = StDone;
                end else if (cnt_q == '0) begin
                    res_d   = ResEq;
                    state_d = StDone;
                end else begin
                    a_sh_d = a_sh_q << DigitW;
                    b_sh_d = b_sh_q << DigitW;
                    cnt_d  = cnt_q - 1'b1;
                end
`else
                sticky_vld_d = first_vld;
                sticky_gt_d  = first_gt;
                if (cnt_q == '0) begin
                    res_d   = first_vld ? res_unequal(first_gt) : ResEq;
                    state_d = StDone;
                end else begin
                    a_sh_d = a_sh_q << DigitW;
                    b_sh_d = b_sh_q << DigitW;
                    cnt_d  = cnt_q - 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
            res_q   <= ResNone;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
            sticky_vld_q <= 1'b0;
            sticky_gt_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
            sticky_vld_q <= sticky_vld_d;
            sticky_gt_q  <= sticky_gt_d;
`endif
        end
    end

    assign busy   = (state_q == StRun);
    assign done   = (state_q == StDone);
    assign a_lt_b = res_q[ResLtIdx];
    assign a_eq_b = res_q[ResEqIdx];
    assign a_gt_b = res_q[ResGtIdx];

endmodule

// File: tb/tb_serial_word_comparator.sv
// Scoreboard bench for serial_word_comparator (WIDTH=8); honours SERIAL_CMP_EARLY_EXIT_EN.
module tb_serial_word_comparator;

    localparam logic [2:0] ELt = 3'b001;
    localparam logic [2:0] EEq = 3'b010;
    localparam logic [2:0] EGt = 3'b100;

    typedef struct {
        logic [2:0] res;
        int         cyc;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, a_lt_b, a_eq_b, a_gt_b;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    serial_word_comparator #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .a_lt_b (a_lt_b),
        .a_eq_b (a_eq_b),
        .a_gt_b (a_gt_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // k = index of first unequal digit, -1 when equal
    function automatic int lat(input int k);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        return (k < 0) ? 5 : k + 2;
`else
        return 5;
`endif
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drives a start in the current cycle T; returns at the sampling point of cycle T+1
    task automatic do_start(input logic [7:0] va, input logic [7:0] vb,
                            input logic [2:0] res, input int k, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        start = 1'b1;
        a     = va;
        b     = vb;
        e.res = res;
        e.cyc = cyc + lat(k);
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        @(negedge clk);
        check({name, " busy@T+1"}, int'(busy), 1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: %0d results pending, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    // Monitor: pops the scoreboard whenever done is seen, checks results hold otherwise
    initial begin : monitor
        logic [2:0] last_res = '0;
        logic [2:0] res;
        exp_t       e;
        forever begin
            @(negedge clk);
            res = {a_gt_b, a_eq_b, a_lt_b};
            if (rst) begin
                last_res = '0;
            end else if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected done: res=%b at cycle %0d, expected none", res, cyc);
                end else begin
                    e = sb.pop_front();
                    check({e.name, " result"}, int'(res), int'(e.res));
                    check({e.name, " done cycle"}, cyc, e.cyc);
                    check({e.name, " busy at done"}, int'(busy), 0);
                end
                last_res = res;
            end else begin
                check("result hold", int'(res), int'(last_res));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : stimulus
        logic [7:0] va[7] = '{8'hA5, 8'h80, 8'h12, 8'h37, 8'h4F, 8'hFF, 8'h00};
        logic [7:0] vb[7] = '{8'hA5, 8'h7F, 8'h13, 8'h3B, 8'h70, 8'h00, 8'h00};
        logic [2:0] vr[7] = '{EEq, EGt, ELt, ELt, ELt, EGt, EEq};
        int         vk[7] = '{-1, 0, 3, 2, 1, 0, -1};
        int         n;
        exp_t       e;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset results", int'({a_gt_b, a_eq_b, a_lt_b}), 0);

        for (int i = 0; i < 7; i++) begin
            do_start(va[i], vb[i], vr[i], vk[i], $sformatf("vec%0d", i));
            drain($sformatf("vec%0d", i));
        end

        // Start during busy must be ignored
        do_start(8'h40, 8'h41, ELt, 3, "ignore");
        #1;
        start = 1'b1;
        a = 8'hFF;
        b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        drain("ignore");
        repeat (3) @(negedge clk);

        // Back-to-back: start in the DONE cycle of a gt compare
        do_start(8'h80, 8'h7F, EGt, 0, "b2b first");
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b done seen", int'(done), 1);
        start = 1'b1;
        a = 8'h00;
        b = 8'h03;
        e.res = ELt;
        e.cyc = cyc + lat(3);
        e.name = "b2b second";
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("b2b busy no idle", int'(busy), 1);
        drain("b2b");

        // Reset in cycle T+2 of a compare
        do_start(8'h12, 8'h13, ELt, 3, "rst abort");
        @(posedge clk);
        #1;
        rst = 1'b1;
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        check("abort results", int'({a_gt_b, a_eq_b, a_lt_b}), 0);
        repeat (8) @(negedge clk);

        do_start(8'hC3, 8'hC3, EEq, -1, "post reset");
        drain("post reset");
        repeat (4) @(negedge clk);
        check("scoreboard empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
